// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared definitions for the AES-128 inverse key scheduler.
// Contents: the FSM state enum, the round count, the S-box and RCON tables,
// and the rot_word / xtime / rcon_inv helper functions.
package aes_inv_key_schedule_pkg;

  typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

  localparam int unsigned NR = 10;

  // Round constants for rounds 1..10. Entry 0 is round 1.
  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  // AES forward S-box. Entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant used when stepping back from round r (1..10); 0 otherwise.
  function automatic logic [7:0] rcon_inv(input logic [3:0] r);
    logic [3:0] idx;
    idx = r - 4'd1;
    if (r != 4'd0 && r <= 4'(NR)) return RCON[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key-load and round-key stream bundle for the inverse key scheduler.
// slave : scheduler side (accepts key, produces round keys)
// master: surrounding logic (supplies key, consumes round keys)
interface aes_inv_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_valid, rk_last, busy
  );

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_valid, rk_last, busy
  );
endinterface

// File: rtl/aes_inv_key_schedule_step.sv
// Combinational single AES-128 key-expansion step, forward or inverse.
// key_i: current round key; rcon_i: round constant; dir_i: 0 = forward, 1 = inverse;
// key_o: next (forward) or previous (inverse) round key.
module aes_inv_key_schedule_step
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic         dir_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3, p3, sub_in, sub_out, t;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];
  assign p3 = w3 ^ w2;

  // Single S-box bank shared by both directions.
  assign sub_in = dir_i ? rot_word(p3) : rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .hi_i  (sub_in[8*i+7 -: 4]),
      .lo_i  (sub_in[8*i+3 -: 4]),
      .byte_o(sub_out[8*i+7 -: 8])
    );
  end

  assign t = sub_out ^ {rcon_i, 24'h0};

  always_comb begin
    key_o = '0;
    if (dir_i) begin
      key_o = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
    end else begin
      key_o[127:96] = w0 ^ t;
      key_o[95:64]  = w1 ^ w0 ^ t;
      key_o[63:32]  = w2 ^ w1 ^ w0 ^ t;
      key_o[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
    end
  end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box lookup.
// hi_i/lo_i: high and low nibble of the input byte; byte_o: substituted byte.
module aes_sbox
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [3:0] hi_i,
  input  logic [3:0] lo_i,
  output logic [7:0] byte_o
);
  assign byte_o = SBOX[{hi_i, lo_i}];
endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key scheduler for decryption: expands the cipher key
// forward to round 10, then streams round keys 10..0 using the inverse step.
// clk/rst: clock and synchronous active-high reset.
// bus_io : key load handshake (key_in/key_valid/key_ready), round-key stream
//          (rk_out/rk_round/rk_valid/rk_ready/rk_last) and busy status.
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
(
  input logic                         clk,
  input logic                         rst,
  aes_inv_key_schedule_if.slave       bus_io
);
  localparam logic [3:0] LastRound = 4'(NR);

  state_e       state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic [127:0] step_key;
  logic         step_dir;
  logic [7:0]   step_rcon;

  assign step_dir  = (state_q == StOut);
  assign step_rcon = step_dir ? rcon_inv(round_q) : rcon_q;

  aes_inv_key_schedule_step u_step (
    .key_i (key_q),
    .rcon_i(step_rcon),
    .dir_i (step_dir),
    .key_o (step_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.key_valid) begin
            key_q   <= bus_io.key_in;
            round_q <= '0;
            rcon_q  <= 8'h01;
            state_q <= StFwd;
          end
        end
        StFwd: begin
          key_q   <= step_key;
          round_q <= round_q + 4'd1;
          rcon_q  <= xtime(rcon_q);
          if (round_q == LastRound - 4'd1) state_q <= StOut;
        end
        StOut: begin
          if (bus_io.rk_ready) begin
            if (round_q != 4'd0) begin
              key_q   <= step_key;
              round_q <= round_q - 4'd1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.key_ready = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.rk_valid  = (state_q == StOut);
  assign bus_io.rk_last   = (state_q == StOut) && (round_q == 4'd0);
  assign bus_io.rk_out    = key_q;
  assign bus_io.rk_round  = round_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using FIPS-197 and all-zero keys.
module tb_aes_inv_key_schedule;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  logic [127:0] gold [0:10];

  aes_inv_key_schedule_if bus ();

  aes_inv_key_schedule dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus.slave)
  );

  always #5 clk = ~clk;

  // Present a key at the current negedge; returns at the negedge after acceptance.
  task automatic load_key(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_in = '0; bus.key_valid = 1'b0; bus.rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0) begin
      errors++;
      $display("FAIL reset: got rdy=%b val=%b last=%b busy=%b out=%h rnd=%0d, want 1 0 0 0 0 0",
               bus.key_ready, bus.rk_valid, bus.rk_last, bus.busy, bus.rk_out, bus.rk_round);
    end
  endtask

  task automatic test_fips_stream();
    int lat;
    vectors++;
    if (bus.key_ready !== 1'b1) begin
      errors++; $display("FAIL fips_ready: got %b want 1", bus.key_ready);
    end
    load_key(gold[0]);
    bus.rk_ready = 1'b1;
    lat = 0;
    while (bus.rk_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != 10) begin errors++; $display("FAIL fips_latency: got %0d want 10", lat); end
    for (int r = 10; r >= 0; r--) begin
      vectors++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(r) || bus.rk_out !== gold[r] ||
          bus.rk_last !== (r == 0)) begin
        errors++;
        $display("FAIL fips_r%0d: got out=%h rnd=%0d val=%b last=%b want out=%h rnd=%0d",
                 r, bus.rk_out, bus.rk_round, bus.rk_valid, bus.rk_last, gold[r], r);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_done: got rdy=%b val=%b busy=%b want 1 0 0",
               bus.key_ready, bus.rk_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int exp_r, guard, lat;
    logic rdy;
    bus.rk_ready = 1'b0;
    load_key(gold[0]);
    lat = 0;
    while (bus.rk_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    exp_r = 10; guard = 0;
    while (exp_r >= 0 && guard < 300) begin
      vectors++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(exp_r) || bus.rk_out !== gold[exp_r]) begin
        errors++;
        $display("FAIL bp_r%0d: got out=%h rnd=%0d val=%b want out=%h rnd=%0d val=1",
                 exp_r, bus.rk_out, bus.rk_round, bus.rk_valid, gold[exp_r], exp_r);
      end
      rdy = 1'($urandom_range(0, 1));
      bus.rk_ready = rdy;
      @(negedge clk);
      if (rdy) exp_r--;
      guard++;
    end
    bus.rk_ready = 1'b0;
    vectors++;
    if (exp_r >= 0 || bus.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got remaining=%0d rdy=%b want -1 1", exp_r, bus.key_ready);
    end
  endtask

  task automatic test_key_ignored();
    int lat;
    bus.rk_ready = 1'b1;
    load_key(gold[0]);
    bus.key_in = 128'h0;
    bus.key_valid = 1'b1;
    lat = 0;
    while (bus.rk_valid !== 1'b1 && lat < 40) begin
      vectors++;
      if (bus.key_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL ign_fwd: got rdy=%b busy=%b want 0 1", bus.key_ready, bus.busy);
      end
      @(negedge clk); lat++;
    end
    for (int r = 10; r >= 0; r--) begin
      vectors++;
      if (bus.key_ready !== 1'b0 || bus.rk_round !== 4'(r) || bus.rk_out !== gold[r]) begin
        errors++;
        $display("FAIL ign_r%0d: got out=%h rnd=%0d rdy=%b want out=%h rnd=%0d rdy=0",
                 r, bus.rk_out, bus.rk_round, bus.key_ready, gold[r], r);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.key_ready !== 1'b1) begin
      errors++; $display("FAIL ign_idle: got rdy=%b want 1", bus.key_ready);
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin
      errors++;
      $display("FAIL ign_accept: got busy=%b rdy=%b want 1 0", bus.busy, bus.key_ready);
    end
    lat = 0;
    while (bus.key_ready !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset_mid_stream();
    int guard;
    bus.rk_ready = 1'b1;
    load_key(gold[0]);
    guard = 0;
    while (!(bus.rk_valid === 1'b1 && bus.rk_round === 4'd5) && guard < 60) begin
      @(negedge clk); guard++;
    end
    vectors++;
    if (bus.rk_out !== gold[5]) begin
      errors++; $display("FAIL mid_r5: got %h want %h", bus.rk_out, gold[5]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.key_ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.rk_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b val=%b last=%b busy=%b out=%h rnd=%0d want 1 0 0 0 0 0",
               bus.key_ready, bus.rk_valid, bus.rk_last, bus.busy, bus.rk_out, bus.rk_round);
    end
    @(negedge clk);
    vectors++;
    if (bus.rk_valid !== 1'b0) begin
      errors++; $display("FAIL mid_quiet: got val=%b want 0", bus.rk_valid);
    end
    test_fips_stream();
  endtask

  task automatic test_zero_key();
    int lat;
    bus.rk_ready = 1'b1;
    load_key(128'h0);
    lat = 0;
    while (bus.rk_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != 10 || bus.rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++;
      $display("FAIL zero_r10: got lat=%0d out=%h want 10 b4ef5bcb3e92e21123e951cf6f8f188e",
               lat, bus.rk_out);
    end
    for (int r = 10; r > 0; r--) begin
      vectors++;
      if (bus.rk_round !== 4'(r) || bus.rk_last !== 1'b0) begin
        errors++;
        $display("FAIL zero_rnd%0d: got rnd=%0d last=%b want %0d 0", r, bus.rk_round,
                 bus.rk_last, r);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0 || bus.rk_last !== 1'b1) begin
      errors++;
      $display("FAIL zero_r0: got out=%h rnd=%0d last=%b want 0 0 1", bus.rk_out,
               bus.rk_round, bus.rk_last);
    end
    @(negedge clk);
  endtask

  initial begin
    gold[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    gold[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    gold[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    gold[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    gold[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    gold[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    gold[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    gold[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    gold[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    gold[9]  = 128'hac7766f319fadc2128d12941575c006e;
    gold[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset();
    test_fips_stream();
    test_backpressure();
    test_key_ignored();
    test_reset_mid_stream();
    test_zero_key();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
